mod_mul_blakley: RTL and testbench



---
 rtl/sm2_pkg.sv | 20 ++
 rtl/mod_dbl_add_step.sv | 28 ++
 rtl/mod_mul_blakley.sv | 120 ++++++++++++
 tb/tb_mod_mul_blakley.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2_pkg.sv
// Shared SM2 definitions: curve constants, default datapath width
// and the state encoding of the Blakley modular multiplier.
package sm2_pkg;

   localparam int SM2_WIDTH = 256;

   localparam logic [255:0] SM2_P =
      256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

   localparam logic [255:0] SM2_N =
      256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_RUN   = 2'd2,
      S_FIN   = 2'd3
   } mmb_state_t;

endpackage

// File: rtl/mod_dbl_add_step.sv
// One radix-2 Blakley step: t = (2*acc + addend) mod m, given acc, addend < m.
// Ports: acc, addend, m (WIDTH in); t (WIDTH out). Purely combinational.
module mod_dbl_add_step #(
   parameter int WIDTH = 256
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] addend,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] t
);

   logic [WIDTH+1:0] w_m;
   logic [WIDTH+1:0] w_t0;
   logic [WIDTH+1:0] w_t1;
   logic             w_ge0;
   logic             w_ge1;

   // 2*acc + addend < 3*m, so two guarded subtractions fully reduce it
   assign w_m   = {2'b00, m};
   assign w_t0  = {1'b0, acc, 1'b0} + {2'b00, addend};
   assign w_ge0 = (w_t0 >= w_m);
   assign w_t1  = w_ge0 ? (w_t0 - w_m) : w_t0;
   assign w_ge1 = (w_t1 >= w_m);

   // after the second subtraction the value is < m, so WIDTH bits suffice
   assign t = w_ge1 ? (w_t1[WIDTH-1:0] - m) : w_t1[WIDTH-1:0];

endmodule

// File: rtl/mod_mul_blakley.sv
// Interleaved radix-2 modular multiplier c = (a*b) mod m, run-time modulus.
// Ports: clk, rstn, start, a, b, m in; c, done, busy, err registered out.
module mod_mul_blakley
   import sm2_pkg::*;
#(
   parameter int WIDTH = SM2_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] c,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);

   mmb_state_t       r_state;
   mmb_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_rm;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_done;
   logic             r_busy;
   logic             r_err;
   logic             w_err_n;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH-1:0] w_t;

   assign w_err_n  = (r_rm < WIDTH'(2)) | (r_ra >= r_rm) | (r_rb >= r_rm);
   assign w_addend = r_ra[r_cnt] ? r_rb : '0;

   mod_dbl_add_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .acc   (r_acc),
      .addend(w_addend),
      .m     (r_rm),
      .t     (w_t)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = w_err_n ? S_FIN : S_RUN;
         S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // flags follow the next state so they stay registered yet line up
   // with the state they describe
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ra   <= '0;
         r_rb   <= '0;
         r_rm   <= '0;
         r_acc  <= '0;
         r_c    <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= (w_state_nxt == S_FIN);
         r_busy <= (w_state_nxt != S_IDLE);
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ra  <= a;
                  r_rb  <= b;
                  r_rm  <= m;
                  r_acc <= '0;
               end
            end
            S_CHECK: begin
               if (w_err_n) begin
                  r_c   <= '0;
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= CW'(WIDTH - 1);
                  r_err <= 1'b0;
               end
            end
            S_RUN: begin
               r_acc <= w_t;
               if (r_cnt == '0) begin
                  r_c <= w_t;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign c    = r_c;
   assign done = r_done;
   assign busy = r_busy;
   assign err  = r_err;

endmodule

// File: tb/tb_mod_mul_blakley.sv
// Scoreboard bench for mod_mul_blakley at WIDTH=8 and WIDTH=256.
// Reference results come from plain (a*b)%m arithmetic.
module tb_mod_mul_blakley;
   import sm2_pkg::*;

   typedef struct {
      logic [255:0] c;
      logic         err;
      int           due;
   } exp_t;

   logic clk;
   int   cyc;
   int   total;
   int   bad;

   logic         rstn8,  start8,  done8,  busy8,  err8;
   logic [7:0]   a8, b8, m8, c8;
   logic         rstn256, start256, done256, busy256, err256;
   logic [255:0] a256, b256, m256, c256;

   exp_t q8[$];
   exp_t q256[$];
   logic chk8;
   logic chk256;

   mod_mul_blakley #(.WIDTH(8)) u_d8 (
      .clk(clk), .rstn(rstn8), .start(start8),
      .a(a8), .b(b8), .m(m8),
      .c(c8), .done(done8), .busy(busy8), .err(err8)
   );

   mod_mul_blakley #(.WIDTH(256)) u_d256 (
      .clk(clk), .rstn(rstn256), .start(start256),
      .a(a256), .b(b256), .m(m256),
      .c(c256), .done(done256), .busy(busy256), .err(err256)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [255:0] x,
                                  input logic [255:0] y,
                                  input logic [255:0] md,
                                  input int lat);
      exp_t e;
      logic [511:0] p;
      e.err = (md < 2) || (x >= md) || (y >= md);
      if (e.err) begin
         e.c = '0;
      end else begin
         p = {256'b0, x} * {256'b0, y};
         p = p % {256'b0, md};
         e.c = p[255:0];
      end
      e.due = e.err ? 1 : lat;
      return e;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // monitors: pop on every done and compare result, flag and timing
   always @(negedge clk) begin
      exp_t e;
      if (chk8) begin
         chk8 = 1'b0;
         total++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL d8_fin_exit done=%0b busy=%0b want 0 0", done8, busy8);
         end
      end
      if (done8 === 1'b1) begin
         total++;
         if (q8.size() == 0) begin
            bad++;
            $display("FAIL d8_spurious_done c=%0d err=%0b", c8, err8);
         end else begin
            e = q8.pop_front();
            if (c8 !== e.c[7:0] || err8 !== e.err ||
                cyc != e.due || busy8 !== 1'b1) begin
               bad++;
               $display("FAIL d8_result c=%0d err=%0b cyc=%0d busy=%0b want c=%0d err=%0b cyc=%0d busy=1",
                        c8, err8, cyc, busy8, e.c[7:0], e.err, e.due);
            end
            chk8 = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (chk256) begin
         chk256 = 1'b0;
         total++;
         if (done256 !== 1'b0 || busy256 !== 1'b0) begin
            bad++;
            $display("FAIL d256_fin_exit done=%0b busy=%0b want 0 0", done256, busy256);
         end
      end
      if (done256 === 1'b1) begin
         total++;
         if (q256.size() == 0) begin
            bad++;
            $display("FAIL d256_spurious_done c=%h", c256);
         end else begin
            e = q256.pop_front();
            if (c256 !== e.c || err256 !== e.err || cyc != e.due) begin
               bad++;
               $display("FAIL d256_result c=%h err=%0b cyc=%0d want c=%h err=%0b cyc=%0d",
                        c256, err256, cyc, e.c, e.err, e.due);
            end
            chk256 = 1'b1;
         end
      end
   end

   // called at a negedge; waits for IDLE, pulses start for one edge
   task automatic issue8(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] im);
      exp_t e;
      int n;
      n = 0;
      while (busy8 === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy8 !== 1'b0) begin
         bad++;
         $display("FAIL d8_idle_timeout busy=%0b want 0", busy8);
      end
      a8 = ia; b8 = ib; m8 = im; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      e = model({248'b0, ia}, {248'b0, ib}, {248'b0, im}, 9);
      e.due = cyc + e.due;
      q8.push_back(e);
      total++;
      if (busy8 !== 1'b1) begin
         bad++;
         $display("FAIL d8_busy_rise busy=%0b want 1", busy8);
      end
   endtask

   task automatic issue256(input logic [255:0] ia, input logic [255:0] ib,
                           input logic [255:0] im);
      exp_t e;
      int n;
      n = 0;
      while (busy256 === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy256 !== 1'b0) begin
         bad++;
         $display("FAIL d256_idle_timeout busy=%0b want 0", busy256);
      end
      a256 = ia; b256 = ib; m256 = im; start256 = 1'b1;
      @(negedge clk);
      start256 = 1'b0;
      e = model(ia, ib, im, 257);
      e.due = cyc + e.due;
      q256.push_back(e);
   endtask

   initial begin
      logic [7:0]   ra, rb, rm;
      logic [255:0] xa, xb, xm;
      int n;
      total = 0; bad = 0; chk8 = 1'b0; chk256 = 1'b0;
      rstn8 = 1'b0; rstn256 = 1'b0;
      start8 = 1'b0; start256 = 1'b0;
      a8 = '0; b8 = '0; m8 = '0;
      a256 = '0; b256 = '0; m256 = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({c8, done8, busy8, err8} !== 11'd0) begin
         bad++;
         $display("FAIL d8_reset c=%0d d=%0b b=%0b e=%0b want 0", c8, done8, busy8, err8);
      end
      total++;
      if (c256 !== '0 || {done256, busy256, err256} !== 3'd0) begin
         bad++;
         $display("FAIL d256_reset d=%0b b=%0b e=%0b want 0", done256, busy256, err256);
      end
      rstn8 = 1'b1; rstn256 = 1'b1;
      @(negedge clk);

      issue8(8'd200, 8'd100, 8'd251);
      issue8(8'd250, 8'd250, 8'd251);
      issue8(8'd0,   8'd77,  8'd251);
      issue8(8'd251, 8'd3,   8'd251);
      issue8(8'd5,   8'd3,   8'd1);
      issue8(8'd10,  8'd20,  8'd251);
      issue8(8'd254, 8'd254, 8'd255);

      // start pulses and operand changes during RUN must be ignored
      issue8(8'd123, 8'd45, 8'd251);
      repeat (3) @(negedge clk);
      start8 = 1'b1; a8 = 8'd7; b8 = 8'd9; m8 = 8'd13;
      repeat (2) @(negedge clk);
      start8 = 1'b0; a8 = 8'd1; b8 = 8'd1; m8 = 8'd3;

      // asynchronous reset at E4 of a run aborts it with no done
      issue8(8'd99, 8'd88, 8'd251);
      repeat (4) @(posedge clk);
      #1 rstn8 = 1'b0;
      #1;
      total++;
      if ({c8, done8, busy8, err8} !== 11'd0) begin
         bad++;
         $display("FAIL d8_midrun_reset c=%0d d=%0b b=%0b e=%0b want 0", c8, done8, busy8, err8);
      end
      void'(q8.pop_back());
      repeat (2) @(negedge clk);
      rstn8 = 1'b1;
      @(negedge clk);
      issue8(8'd17, 8'd33, 8'd101);

      for (int i = 0; i < 1000; i++) begin
         rm = 8'($urandom);
         if (($urandom % 16) == 0 || rm == 0) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
         end else begin
            ra = 8'($urandom % rm);
            rb = 8'($urandom % rm);
         end
         issue8(ra, rb, rm);
      end

      issue256(SM2_P - 1, SM2_P - 1, SM2_P);
      issue256(SM2_N - 1, SM2_N - 1, SM2_N);
      issue256(SM2_P, 256'd3, SM2_P);
      for (int i = 0; i < 60; i++) begin
         case (i % 3)
            0:       xm = SM2_P;
            1:       xm = SM2_N;
            default: xm = rnd256() | 256'd1;
         endcase
         xa = rnd256() % xm;
         xb = rnd256() % xm;
         issue256(xa, xb, xm);
      end

      n = 0;
      while ((q8.size() != 0 || q256.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      total++;
      if (q8.size() != 0 || q256.size() != 0) begin
         bad++;
         $display("FAIL drain q8=%0d q256=%0d want 0 0", q8.size(), q256.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
